// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: word loads/stores over a ready-handshaked
// data bus, upstream stall while an access is outstanding, and the MEM/WB register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             in_mem_to_reg,
    input  logic             in_reg_write,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_store_data,
    input  logic [4:0]       in_rd,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic [31:0]      out_wb_data,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             misalign_err,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]    state;
    logic [TW-1:0] tcnt;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_we;

    logic mem_op;
    logic aligned;
    logic timeout_hit;
    logic rd_nonzero;

    assign mem_op      = in_mem_read | in_mem_write;
    assign aligned     = (in_alu_result[1:0] == 2'b00);
    assign timeout_hit = (tcnt == TCNT_LAST);
    assign rd_nonzero  = (in_rd != '0);

    assign dmem_req   = (state == ST_ACCESS);
    assign dmem_we    = bus_we;
    assign dmem_addr  = bus_addr;
    assign dmem_wdata = bus_wdata;

    // The timeout cycle itself releases the stall so EX/MEM advances on the abort edge.
    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE:   stall = mem_op & aligned;
            ST_ACCESS: stall = ~dmem_ready & ~timeout_hit;
            default:   stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op && aligned) begin
                        state     <= ST_ACCESS;
                        tcnt      <= '0;
                        bus_addr  <= in_alu_result;
                        bus_wdata <= in_store_data;
                        bus_we    <= in_mem_write;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready) begin
                        state <= ST_IDLE;
                    end else if (timeout_hit) begin
                        state   <= ST_IDLE;
                        bus_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wb_data   <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (stall) begin
                out_rd        <= '0;
                out_reg_write <= 1'b0;
            end else if (state == ST_ACCESS) begin
                if (dmem_ready) begin
                    // A combined read+write is treated as a store: no load data returned.
                    out_wb_data   <= (in_mem_to_reg && !in_mem_write) ? dmem_rdata : in_alu_result;
                    out_rd        <= in_rd;
                    out_reg_write <= in_reg_write & rd_nonzero & ~in_mem_write;
                end else begin
                    out_rd        <= '0;
                    out_reg_write <= 1'b0;
                end
            end else if (mem_op) begin
                misalign_err  <= 1'b1;
                out_wb_data   <= in_alu_result;
                out_rd        <= in_rd;
                out_reg_write <= 1'b0;
            end else begin
                out_wb_data   <= in_alu_result;
                out_rd        <= in_rd;
                out_reg_write <= in_reg_write & rd_nonzero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, load, store,
// misaligned access, bus timeout and mid-access reset.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        misalign_err;
    logic        bus_err;
    logic [15:0] stall_count;

    int unsigned n_tests;
    int unsigned n_fail;

    mem_access_stage #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_mem_to_reg(in_mem_to_reg),
        .in_reg_write (in_reg_write),
        .in_alu_result(in_alu_result),
        .in_store_data(in_store_data),
        .in_rd        (in_rd),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .out_wb_data  (out_wb_data),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_mem_to_reg = 1'b0;
        in_reg_write  = 1'b0;
        in_alu_result = '0;
        in_store_data = '0;
        in_rd         = '0;
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic m2r,
                            input logic rw, input logic [31:0] alu,
                            input logic [31:0] sdata, input logic [4:0] rd);
        in_mem_read   = rd_en;
        in_mem_write  = wr_en;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_alu_result = alu;
        in_store_data = sdata;
        in_rd         = rd;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        drive_nop();
        step();
        step();
        check("rst_wb_data",  out_wb_data,   32'h0);
        check("rst_rd",       {27'h0, out_rd}, 32'h0);
        check("rst_reg_write", {31'h0, out_reg_write}, 32'h0);
        check("rst_req",      {31'h0, dmem_req}, 32'h0);
        check("rst_bus_err",  {31'h0, bus_err}, 32'h0);
        check("rst_stall_cnt", {16'h0, stall_count}, 32'h0);
        reset = 1'b0;
        step();

        // ALU op; dmem_ready asserted outside ACCESS must be ignored
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd5);
        dmem_ready = 1'b1;
        #1;
        check("alu_stall", {31'h0, stall}, 32'h0);
        check("alu_req",   {31'h0, dmem_req}, 32'h0);
        step();
        dmem_ready = 1'b0;
        check("alu_wb",   out_wb_data, 32'h0000_1234);
        check("alu_rd",   {27'h0, out_rd}, 32'd5);
        check("alu_rw",   {31'h0, out_reg_write}, 32'h1);

        // rd = x0 never writes
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 5'd0);
        step();
        check("x0_rw", {31'h0, out_reg_write}, 32'h0);

        // Load from 0x100, ready on first ACCESS cycle
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7);
        #1;
        check("ld_stall_idle", {31'h0, stall}, 32'h1);
        check("ld_req_idle",   {31'h0, dmem_req}, 32'h0);
        step();
        check("ld_req",    {31'h0, dmem_req}, 32'h1);
        check("ld_addr",   dmem_addr, 32'h0000_0100);
        check("ld_we",     {31'h0, dmem_we}, 32'h0);
        check("ld_bubble_rw", {31'h0, out_reg_write}, 32'h0);
        check("ld_bubble_rd", {27'h0, out_rd}, 32'h0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_stall_rdy", {31'h0, stall}, 32'h0);
        step();
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        drive_nop();
        check("ld_wb",   out_wb_data, 32'hDEAD_BEEF);
        check("ld_rd",   {27'h0, out_rd}, 32'd7);
        check("ld_rw",   {31'h0, out_reg_write}, 32'h1);
        check("ld_req_done", {31'h0, dmem_req}, 32'h0);
        check("ld_stall_cnt", {16'h0, stall_count}, 32'd1);

        // Store 0xCAFEF00D to 0x204, ready on the 4th ACCESS cycle; reg_write must be suppressed
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 5'd3);
        step();
        for (int i = 0; i < 3; i++) begin
            check("st_req",   {31'h0, dmem_req}, 32'h1);
            check("st_we",    {31'h0, dmem_we}, 32'h1);
            check("st_addr",  dmem_addr, 32'h0000_0204);
            check("st_wdata", dmem_wdata, 32'hCAFE_F00D);
            check("st_stall", {31'h0, stall}, 32'h1);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check("st_stall_rdy", {31'h0, stall}, 32'h0);
        check("st_wdata_last", dmem_wdata, 32'hCAFE_F00D);
        step();
        dmem_ready = 1'b0;
        drive_nop();
        check("st_rw",  {31'h0, out_reg_write}, 32'h0);
        check("st_req_done", {31'h0, dmem_req}, 32'h0);
        check("st_stall_cnt", {16'h0, stall_count}, 32'd5);

        // Misaligned load from 0x102
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd4);
        #1;
        check("mis_stall", {31'h0, stall}, 32'h0);
        step();
        drive_nop();
        check("mis_err",  {31'h0, misalign_err}, 32'h1);
        check("mis_rw",   {31'h0, out_reg_write}, 32'h0);
        check("mis_req",  {31'h0, dmem_req}, 32'h0);
        step();
        check("mis_err_pulse", {31'h0, misalign_err}, 32'h0);

        // Load that never sees ready: abort after 16 ACCESS cycles
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd9);
        step();
        for (int i = 0; i < 15; i++) begin
            check("to_req",   {31'h0, dmem_req}, 32'h1);
            check("to_stall", {31'h0, stall}, 32'h1);
            step();
        end
        check("to_req_last",   {31'h0, dmem_req}, 32'h1);
        check("to_stall_last", {31'h0, stall}, 32'h0);
        check("to_bus_err_pre", {31'h0, bus_err}, 32'h0);
        step();
        drive_nop();
        check("to_req_drop", {31'h0, dmem_req}, 32'h0);
        check("to_bus_err",  {31'h0, bus_err}, 32'h1);
        check("to_rw",       {31'h0, out_reg_write}, 32'h0);
        check("to_stall_cnt", {16'h0, stall_count}, 32'd21);
        step();
        step();
        check("to_bus_err_sticky", {31'h0, bus_err}, 32'h1);
        check("to_stall_free",     {31'h0, stall}, 32'h0);

        // Reset asserted during the 2nd ACCESS cycle
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd11);
        step();
        step();
        check("rst2_req_before", {31'h0, dmem_req}, 32'h1);
        reset = 1'b1;
        drive_nop();
        #1;
        check("rst2_req",     {31'h0, dmem_req}, 32'h0);
        check("rst2_stall",   {31'h0, stall}, 32'h0);
        check("rst2_bus_err", {31'h0, bus_err}, 32'h0);
        check("rst2_wb",      out_wb_data, 32'h0);
        check("rst2_rw",      {31'h0, out_reg_write}, 32'h0);
        check("rst2_stall_cnt", {16'h0, stall_count}, 32'h0);
        step();
        reset = 1'b0;
        step();

        // Recovery after reset
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 32'h0, 5'd12);
        step();
        check("rec_wb", out_wb_data, 32'h0000_BEEF);
        check("rec_rd", {27'h0, out_rd}, 32'd12);
        check("rec_rw", {31'h0, out_reg_write}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
